// File: rtl/if_queue_if.sv
// Valid/ready stream carrying one fetched entry {pc, insn, predicted-taken}.
//   valid  producer has an entry on pc/insn/predt
//   ready  consumer accepts the entry this cycle
//   pc     entry pc
//   insn   entry instruction
//   predt  entry predicted-taken flag
// master: drives the entry (producer side); slave: receives it and drives ready.
interface if_queue_if #(
  parameter int PC_W   = 32,
  parameter int INSN_W = 32
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [INSN_W-1:0] insn;
  logic              predt;

  modport master (output valid, pc, insn, predt, input ready);
  modport slave  (input valid, pc, insn, predt, output ready);
endinterface

// File: rtl/if_queue.sv
// IF->ID instruction queue: circular FIFO of DEPTH fetched entries.
//   clk     rising-edge clock
//   rst     asynchronous reset, active-high
//   cpu_en  global enable; 0 freezes all queue state and blocks push/pop
//   flush   discard every entry (redirect); overrides cpu_en
//   enq     fetch side stream (slave): in_valid/in_ready/in_pc/in_insn/in_predt
//   deq     decode side stream (master): out_valid/out_ready/out_pc/out_insn/out_predt
//   count   number of occupied entries, 0..DEPTH
module if_queue #(
  parameter  int PC_W   = 32,
  parameter  int INSN_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_en,
  input  logic             flush,
  if_queue_if.slave        enq,
  if_queue_if.master       deq,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PC_W + INSN_W + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [ENT_W-1:0] head;
  logic             full;
  logic             not_empty;
  logic             push;
  logic             pop;

  assign full      = (cnt == CNT_W'(DEPTH));
  assign not_empty = (cnt != '0);

  // in_ready uses only registered state and enables, so a full queue refuses
  // a push even when decode pops in the same cycle.
  assign enq.ready = !rst && cpu_en && !full;

  assign push = enq.valid && enq.ready && !flush;
  assign pop  = not_empty && deq.ready && cpu_en && !flush;

  assign head      = mem[rd_ptr];
  assign deq.valid = not_empty;
  assign deq.pc    = not_empty ? head[ENT_W-1 -: PC_W]   : '0;
  assign deq.insn  = not_empty ? head[INSN_W:1]          : '0;
  assign deq.predt = not_empty ? head[0]                 : 1'b0;
  assign count     = cnt;

  // Storage is intentionally not reset; cnt gates visibility of stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {enq.pc, enq.insn, enq.predt};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// Self-checking bench for if_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_queue;
  localparam int PC_W   = 32;
  localparam int INSN_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  typedef logic [PC_W+INSN_W:0] ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_en;
  logic             flush;
  logic [CNT_W-1:0] count;

  if_queue_if #(.PC_W(PC_W), .INSN_W(INSN_W)) enq ();
  if_queue_if #(.PC_W(PC_W), .INSN_W(INSN_W)) deq ();

  if_queue #(.PC_W(PC_W), .INSN_W(INSN_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .cpu_en (cpu_en),
    .flush  (flush),
    .enq    (enq),
    .deq    (deq),
    .count  (count)
  );

  always #5 clk = ~clk;

  ent_t model[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the handshake rules at the rising edge.
  task automatic step(input logic r, input logic en, input logic fl,
                      input logic iv, input logic ordy,
                      input logic [31:0] pc, input logic pt);
    logic [31:0] insn;
    logic        exp_rdy;
    logic        push;
    logic        pop;
    ent_t        hd;
    insn       = (pc * 32'd3) ^ 32'hA5A5_0000;
    rst        = r;
    cpu_en     = en;
    flush      = fl;
    enq.valid  = iv;
    enq.pc     = pc;
    enq.insn   = insn;
    enq.predt  = pt;
    deq.ready  = ordy;
    if (r) model.delete();
    #1;
    exp_rdy = !r && en && (model.size() < DEPTH);
    hd      = (model.size() != 0) ? model[0] : '0;
    chk("in_ready",  64'(enq.ready), 64'(exp_rdy));
    chk("out_valid", 64'(deq.valid), 64'(model.size() != 0));
    chk("count",     64'(count),     64'(model.size()));
    chk("out_pc",    64'(deq.pc),    64'(hd[64:33]));
    chk("out_insn",  64'(deq.insn),  64'(hd[32:1]));
    chk("out_predt", 64'(deq.predt), 64'(hd[0]));
    push = iv && exp_rdy && !fl;
    pop  = (model.size() != 0) && ordy && en && !fl;
    @(posedge clk);
    if (r || fl) begin
      model.delete();
    end else begin
      if (pop)  void'(model.pop_front());
      if (push) model.push_back({pc, insn, pt});
    end
    #1;
  endtask

  initial begin
    int unsigned pc;
    logic [31:0] rnd;

    // Reset with in_valid asserted, then release.
    step(1, 1, 0, 1, 1, 32'h44, 1);
    step(1, 1, 0, 1, 1, 32'h48, 0);
    chk("rst_count", 64'(count), 64'd0);

    // Fill to DEPTH with decode stalled; fifth entry waits for a pop.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 32'(i * 4), i[0]);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head",  64'(deq.pc), 64'h0);
    step(0, 1, 0, 1, 0, 32'h10, 0);
    step(0, 1, 0, 1, 0, 32'h10, 0);
    // Full with simultaneous pop: pop taken, push refused.
    step(0, 1, 0, 1, 1, 32'h10, 0);
    chk("full_pop_count", 64'(count), 64'd3);
    step(0, 1, 0, 1, 1, 32'h10, 0);
    chk("push_pop_count", 64'(count), 64'd3);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 32'h0, 0);
    chk("drained", 64'(count), 64'd0);

    // Streaming 20 entries; both pointers wrap several times.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 1, 32'(i * 4), i[1]);
    chk("stream_count", 64'(count), 64'd1);
    chk("stream_last",  64'(deq.pc), 64'h4C);
    step(0, 1, 0, 0, 1, 32'h0, 0);

    // Flush with cpu_en low and in_valid high.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 32'(32'h40 + i * 4), 1);
    step(0, 0, 1, 1, 1, 32'h99, 1);
    chk("flush_count", 64'(count), 64'd0);
    step(0, 1, 0, 1, 0, 32'h80, 1);
    chk("flush_push_pc", 64'(deq.pc), 64'h80);
    step(0, 1, 0, 0, 1, 32'h0, 0);

    // Freeze with two entries while fetch and decode both request.
    step(0, 1, 0, 1, 0, 32'h100, 0);
    step(0, 1, 0, 1, 0, 32'h104, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 32'hF00, 1);
    chk("freeze_count", 64'(count), 64'd2);
    chk("freeze_head",  64'(deq.pc), 64'h100);
    step(0, 1, 0, 0, 1, 32'h0, 0);
    step(0, 1, 0, 0, 1, 32'h0, 0);

    // Reset asserted mid-operation, then immediate push after release.
    step(0, 1, 0, 1, 0, 32'h200, 0);
    step(0, 1, 0, 1, 0, 32'h204, 0);
    step(1, 1, 0, 1, 0, 32'h208, 0);
    step(0, 1, 0, 1, 0, 32'h20C, 1);
    chk("post_rst_head", 64'(deq.pc), 64'h20C);

    // Random traffic.
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      step(rnd[5:0] == 6'd0, rnd[7:6] != 2'b00, rnd[11:8] == 4'd0,
           rnd[12] | rnd[13], rnd[14] & (rnd[15] | rnd[16]), 32'(pc), rnd[17]);
      pc += 4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
